// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO in front of a UART transmitter.
// The core pushes bytes; the block pops one at a time and hands each to the
// transmitter with a single-cycle tx_start. After each start it holds off for
// a full frame, then waits for tx_busy low, so starts stay spaced even when
// the transmitter never raises tx_busy.
module uart_tx_buffer #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata
);

    localparam int DEPTH      = 1 << DEPTH_LOG2;
    // A 10-bit frame spans 20 half-bit periods.
    localparam int FRAME_CLKS = 20 * CLK_PER_HALF_BIT;
    localparam int CNT_W      = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits match.
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          mem_q [DEPTH];

    logic                overflow_q, overflow_d;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          sdata_q, sdata_d;

    logic                wr_accept;
    logic                pop;
    logic [7:0]          head_byte;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign tx_start  = tx_start_q;
    assign sdata     = sdata_q;

    // Full is taken from the registered pointers, so a pop in the same cycle
    // does not make room for a write arriving while full.
    assign wr_accept = wr_en && !full;
    // START is only entered with data queued, so the pop never underflows.
    assign pop       = (state_q == ST_START);
    assign head_byte = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Pointer advance and sticky drop flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Next-state logic for the start / frame-hold / drain sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        sdata_d    = sdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                sdata_d    = head_byte;
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                // tx_busy is deliberately ignored here: the hold alone
                // guarantees frame spacing.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            sdata_q    <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            sdata_q    <= sdata_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule
